// File: rtl/fejkon_fc_inject.sv
// +----------------------------------------------------------------------------+
// | Module  : fejkon_fc_inject                                                 |
// | Purpose : packet-granular merge of a traffic stream and a pattern          |
// |           generator stream, with an Avalon-MM control/status block.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fejkon_fc_inject #(
  parameter int DATA_WIDTH    = 256,
  parameter int CHANNEL_WIDTH = 4,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8)
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [CHANNEL_WIDTH-1:0] st_in_channel,
  input  logic [DATA_WIDTH-1:0]    st_in_data,
  input  logic [EMPTY_WIDTH-1:0]   st_in_empty,
  input  logic                     st_in_startofpacket,
  input  logic                     st_in_endofpacket,
  input  logic                     st_in_valid,
  output logic                     st_in_ready,

  input  logic [CHANNEL_WIDTH-1:0] gen_channel,
  input  logic [DATA_WIDTH-1:0]    gen_data,
  input  logic [EMPTY_WIDTH-1:0]   gen_empty,
  input  logic                     gen_startofpacket,
  input  logic                     gen_endofpacket,
  input  logic                     gen_valid,
  output logic                     gen_ready,

  output logic [CHANNEL_WIDTH-1:0] st_out_channel,
  output logic [DATA_WIDTH-1:0]    st_out_data,
  output logic [EMPTY_WIDTH-1:0]   st_out_empty,
  output logic                     st_out_startofpacket,
  output logic                     st_out_endofpacket,
  output logic                     st_out_valid,
  input  logic                     st_out_ready,

  input  logic [7:0]               csr_address,
  input  logic                     csr_read,
  input  logic                     csr_write,
  input  logic [31:0]              csr_writedata,
  output logic [31:0]              csr_readdata
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_IN_PKT   = 2'd1;
  localparam logic [1:0]  S_GEN_PKT  = 2'd2;
  localparam logic        SRC_IN     = 1'b0;
  localparam logic        SRC_GEN    = 1'b1;
  localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;

  logic [1:0]               state_q, state_d;
  logic                     last_src_q, last_src_d;
  logic [1:0]               mode_q;
  logic                     override_q;
  logic [CHANNEL_WIDTH-1:0] ovr_channel_q;
  logic [31:0]              inject_count_q, inject_count_d;
  logic [31:0]              in_pkts_q, in_pkts_d;
  logic [31:0]              gen_pkts_q, gen_pkts_d;
  logic [31:0]              drop_count_q, drop_count_d;
  logic [31:0]              csr_readdata_q, csr_readdata_d;

  logic [1:0]  w_state;
  logic        w_inject_en, w_in_elig, w_gen_elig;
  logic        w_in_fire, w_gen_fire, w_drop;
  logic [31:0] w_ctrl_rd;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == C_ALL_ONES) ? v : v + 32'd1;
  endfunction

  // Reset forces the datapath view to IDLE so handshakes are blocked while reset is high.
  assign w_state     = reset ? S_IDLE : state_q;
  assign w_inject_en = (mode_q == 2'd2) || ((mode_q == 2'd1) && (inject_count_q != 32'd0));
  assign w_in_elig   = st_in_valid && st_in_startofpacket;
  assign w_gen_elig  = gen_valid && gen_startofpacket && w_inject_en;
  assign w_in_fire   = (w_state == S_IN_PKT) && st_in_valid && st_in_ready;
  assign w_gen_fire  = (w_state == S_GEN_PKT) && gen_valid && gen_ready;
  assign w_drop      = (w_state == S_IDLE) && st_in_ready;

  always_comb begin
    st_in_ready          = 1'b0;
    gen_ready            = 1'b0;
    st_out_channel       = '0;
    st_out_data          = '0;
    st_out_empty         = '0;
    st_out_startofpacket = 1'b0;
    st_out_endofpacket   = 1'b0;
    st_out_valid         = 1'b0;
    case (w_state)
      S_IN_PKT: begin
        st_out_channel       = st_in_channel;
        st_out_data          = st_in_data;
        st_out_empty         = st_in_empty;
        st_out_startofpacket = st_in_startofpacket;
        st_out_endofpacket   = st_in_endofpacket;
        st_out_valid         = st_in_valid;
        st_in_ready          = st_out_ready;
      end
      S_GEN_PKT: begin
        st_out_channel       = override_q ? ovr_channel_q : gen_channel;
        st_out_data          = gen_data;
        st_out_empty         = gen_empty;
        st_out_startofpacket = gen_startofpacket;
        st_out_endofpacket   = gen_endofpacket;
        st_out_valid         = gen_valid;
        gen_ready            = st_out_ready;
      end
      default: st_in_ready = !reset && st_in_valid && !st_in_startofpacket;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    case (state_q)
      S_IDLE: begin
        if (w_in_elig && w_gen_elig) begin
          state_d = (last_src_q == SRC_GEN) ? S_IN_PKT : S_GEN_PKT;
        end else if (w_in_elig) begin
          state_d = S_IN_PKT;
        end else if (w_gen_elig) begin
          state_d = S_GEN_PKT;
        end
      end
      S_IN_PKT: if (w_in_fire && st_in_endofpacket) begin
        state_d    = S_IDLE;
        last_src_d = SRC_IN;
      end
      S_GEN_PKT: if (w_gen_fire && gen_endofpacket) begin
        state_d    = S_IDLE;
        last_src_d = SRC_GEN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inject_count_d = inject_count_q;
    if (csr_write && (csr_address == 8'h01)) begin
      inject_count_d = csr_writedata;
    end else if (w_gen_fire && gen_startofpacket && (mode_q == 2'd1) && (inject_count_q != 32'd0)) begin
      inject_count_d = inject_count_q - 32'd1;
    end

    in_pkts_d    = (w_in_fire && st_in_endofpacket) ? sat_inc(in_pkts_q) : in_pkts_q;
    gen_pkts_d   = (w_gen_fire && gen_endofpacket) ? sat_inc(gen_pkts_q) : gen_pkts_q;
    drop_count_d = w_drop ? sat_inc(drop_count_q) : drop_count_q;
    // A clear write takes priority over an increment in the same cycle.
    if (csr_write && (csr_address == 8'h02)) in_pkts_d    = '0;
    if (csr_write && (csr_address == 8'h03)) gen_pkts_d   = '0;
    if (csr_write && (csr_address == 8'h04)) drop_count_d = '0;
  end

  always_comb begin
    w_ctrl_rd                    = '0;
    w_ctrl_rd[1:0]               = mode_q;
    w_ctrl_rd[2]                 = override_q;
    w_ctrl_rd[8 +: CHANNEL_WIDTH] = ovr_channel_q;
    csr_readdata_d = csr_readdata_q;
    if (csr_read) begin
      case (csr_address)
        8'h00:   csr_readdata_d = w_ctrl_rd;
        8'h01:   csr_readdata_d = inject_count_q;
        8'h02:   csr_readdata_d = in_pkts_q;
        8'h03:   csr_readdata_d = gen_pkts_q;
        8'h04:   csr_readdata_d = drop_count_q;
        8'h05:   csr_readdata_d = {29'd0, last_src_q, state_q};
        default: csr_readdata_d = C_ALL_ONES;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      last_src_q     <= SRC_GEN;
      mode_q         <= 2'd0;
      override_q     <= 1'b0;
      ovr_channel_q  <= '0;
      inject_count_q <= '0;
      in_pkts_q      <= '0;
      gen_pkts_q     <= '0;
      drop_count_q   <= '0;
      csr_readdata_q <= '0;
    end else begin
      state_q        <= state_d;
      last_src_q     <= last_src_d;
      inject_count_q <= inject_count_d;
      in_pkts_q      <= in_pkts_d;
      gen_pkts_q     <= gen_pkts_d;
      drop_count_q   <= drop_count_d;
      csr_readdata_q <= csr_readdata_d;
      if (csr_write && (csr_address == 8'h00)) begin
        mode_q        <= csr_writedata[1:0];
        override_q    <= csr_writedata[2];
        ovr_channel_q <= csr_writedata[8 +: CHANNEL_WIDTH];
      end
    end
  end

  assign csr_readdata = csr_readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_fejkon_fc_inject.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_fejkon_fc_inject                                              |
// | Purpose : directed scenarios with random payloads for fejkon_fc_inject.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fejkon_fc_inject;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int EW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] st_in_channel, gen_channel, st_out_channel;
  logic [DW-1:0] st_in_data, gen_data, st_out_data;
  logic [EW-1:0] st_in_empty, gen_empty, st_out_empty;
  logic          st_in_startofpacket, st_in_endofpacket, st_in_valid, st_in_ready;
  logic          gen_startofpacket, gen_endofpacket, gen_valid, gen_ready;
  logic          st_out_startofpacket, st_out_endofpacket, st_out_valid, st_out_ready;
  logic [7:0]    csr_address;
  logic          csr_read, csr_write;
  logic [31:0]   csr_writedata, csr_readdata;

  beat_t inq[$], genq[$], outq[$], expq[$];
  bit    rdy_rand;
  bit    gen_ready_seen;
  int    checks = 0;
  int    errors = 0;

  fejkon_fc_inject #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW)) dut (
    .clk(clk), .reset(reset),
    .st_in_channel(st_in_channel), .st_in_data(st_in_data), .st_in_empty(st_in_empty),
    .st_in_startofpacket(st_in_startofpacket), .st_in_endofpacket(st_in_endofpacket),
    .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
    .gen_channel(gen_channel), .gen_data(gen_data), .gen_empty(gen_empty),
    .gen_startofpacket(gen_startofpacket), .gen_endofpacket(gen_endofpacket),
    .gen_valid(gen_valid), .gen_ready(gen_ready),
    .st_out_channel(st_out_channel), .st_out_data(st_out_data), .st_out_empty(st_out_empty),
    .st_out_startofpacket(st_out_startofpacket), .st_out_endofpacket(st_out_endofpacket),
    .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present queue heads, record the output beat, retire accepted beats.
  task automatic cycle();
    bit in_fire, gen_fire;
    if (inq.size() > 0) begin
      {st_in_data, st_in_channel, st_in_empty, st_in_startofpacket, st_in_endofpacket} = inq[0];
      st_in_valid = 1'b1;
    end else begin
      {st_in_data, st_in_channel, st_in_empty, st_in_startofpacket, st_in_endofpacket} = '0;
      st_in_valid = 1'b0;
    end
    if (genq.size() > 0) begin
      {gen_data, gen_channel, gen_empty, gen_startofpacket, gen_endofpacket} = genq[0];
      gen_valid = 1'b1;
    end else begin
      {gen_data, gen_channel, gen_empty, gen_startofpacket, gen_endofpacket} = '0;
      gen_valid = 1'b0;
    end
    st_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    in_fire  = st_in_valid && st_in_ready;
    gen_fire = gen_valid && gen_ready;
    if (gen_ready) gen_ready_seen = 1'b1;
    if (st_out_valid && st_out_ready)
      outq.push_back({st_out_data, st_out_channel, st_out_empty, st_out_startofpacket, st_out_endofpacket});
    @(posedge clk);
    if (in_fire)  void'(inq.pop_front());
    if (gen_fire) void'(genq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    cycle();
    csr_write = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] e);
    csr_address = a; csr_read = 1'b1;
    cycle();
    csr_read = 1'b0;
    chk(tag, 64'(csr_readdata), 64'(e));
  endtask

  // Appends a packet to a source queue; optionally appends what the output should carry.
  task automatic push_pkt(input bit to_gen, input int len, input logic [CW-1:0] ch,
                          input bit to_exp, input logic [CW-1:0] exp_ch);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = $urandom;
      b.ch    = ch;
      b.empty = EW'($urandom_range(0, 3));
      b.sop   = (i == 0);
      b.eop   = (i == len - 1);
      if (to_gen) genq.push_back(b); else inq.push_back(b);
      if (to_exp) begin
        b.ch = exp_ch;
        expq.push_back(b);
      end
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
    outq.delete();
    expq.delete();
  endtask

  initial begin
    int n;
    logic [CW-1:0] c;
    reset = 1'b1; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    rdy_rand = 1'b0; gen_ready_seen = 1'b0;
    push_pkt(1'b0, 2, 4'd1, 1'b0, 4'd0);
    void'(inq.pop_front());
    run(2);
    chk("rst_in_ready", 64'(st_in_ready), 64'd0);
    chk("rst_gen_ready", 64'(gen_ready), 64'd0);
    chk("rst_out_valid", 64'(st_out_valid), 64'd0);
    inq.delete();
    reset = 1'b0;
    chk("rst_readdata", 64'(csr_readdata), 64'd0);
    chk_reg("rst_status", 8'h05, 32'h4);
    chk_reg("rst_ctrl", 8'h00, 32'h0);
    chk_reg("rst_inject", 8'h01, 32'h0);
    chk_reg("unmapped", 8'h07, 32'hFFFF_FFFF);

    // Mode 3 behaves as off; unused CTRL bits read back as zero.
    csr_wr(8'h00, 32'hFFFF_FFFF);
    chk_reg("ctrl_mask", 8'h00, 32'h0000_0F07);
    push_pkt(1'b1, 2, 4'd3, 1'b0, 4'd0);
    run(10);
    chk("mode3_no_out", 64'(outq.size()), 64'd0);
    chk("mode3_no_gen_ready", 64'(gen_ready_seen), 64'd0);
    csr_wr(8'h00, 32'h0);

    // Mode 0: one input packet, generator stays valid but is never granted.
    gen_ready_seen = 1'b0;
    c = CW'($urandom);
    push_pkt(1'b0, 3, c, 1'b1, c);
    cycle();
    chk("in_grant_latency", 64'(outq.size()), 64'd0);
    run(3);
    chk("in_beats_done", 64'(outq.size()), 64'd3);
    run(4);
    cmp_stream("in_pkt");
    chk_reg("in_pkts_1", 8'h02, 32'd1);
    chk("mode0_gen_ready", 64'(gen_ready_seen), 64'd0);
    genq.delete();

    // Non-SOP beats while idle are swallowed and counted.
    push_pkt(1'b0, 1, 4'd2, 1'b0, 4'd0);
    push_pkt(1'b0, 1, 4'd2, 1'b0, 4'd0);
    inq[0].sop = 1'b0; inq[1].sop = 1'b0;
    run(6);
    chk("drop_consumed", 64'(inq.size()), 64'd0);
    chk("drop_no_out", 64'(outq.size()), 64'd0);
    chk_reg("drop_count", 8'h04, 32'd2);

    // Count mode: exactly two generator packets leave.
    csr_wr(8'h01, 32'd2);
    csr_wr(8'h00, 32'd1);
    rdy_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = CW'($urandom);
      push_pkt(1'b1, 2, c, i < 2, c);
    end
    run(200);
    cmp_stream("count_mode");
    chk("count_left", 64'(genq.size()), 64'd4);
    chk_reg("count_inject", 8'h01, 32'd0);
    chk_reg("count_gen_pkts", 8'h03, 32'd2);
    genq.delete();

    // Continuous mode with both sources busy: strict IN/GEN alternation, IN first.
    csr_wr(8'h02, 32'd0);
    csr_wr(8'h03, 32'd0);
    csr_wr(8'h00, 32'd2);
    for (int i = 0; i < 4; i++) begin
      c = CW'($urandom);
      push_pkt(1'b0, int'($urandom_range(1, 4)), c, 1'b1, c);
      c = CW'($urandom);
      push_pkt(1'b1, int'($urandom_range(1, 4)), c, 1'b1, c);
    end
    run(400);
    cmp_stream("alternate");
    chk_reg("alt_in_pkts", 8'h02, 32'd4);
    chk_reg("alt_gen_pkts", 8'h03, 32'd4);

    // Channel override; switching off mid-packet lets the packet finish.
    rdy_rand = 1'b0;
    csr_wr(8'h00, 32'h0000_0506);
    for (int i = 0; i < 3; i++) push_pkt(1'b1, 4, 4'd2, i == 0, 4'd5);
    n = 0;
    while (outq.size() < 1 && n < 50) begin cycle(); n++; end
    chk("ovr_first_beat", 64'(n < 50), 64'd1);
    csr_wr(8'h00, 32'h0000_0504);
    run(30);
    cmp_stream("override");
    chk("ovr_left", 64'(genq.size()), 64'd8);
    chk_reg("ovr_status", 8'h05, 32'h4);
    genq.delete();

    // A write to INJECT_COUNT beats a concurrent decrement; a clear beats an increment.
    csr_wr(8'h01, 32'd5);
    csr_wr(8'h00, 32'd1);
    push_pkt(1'b1, 1, 4'd0, 1'b0, 4'd0);
    cycle();
    csr_wr(8'h01, 32'd9);
    run(4);
    chk_reg("inject_write_wins", 8'h01, 32'd9);
    push_pkt(1'b1, 1, 4'd0, 1'b0, 4'd0);
    run(5);
    chk_reg("inject_decrement", 8'h01, 32'd8);
    csr_wr(8'h00, 32'd0);
    csr_wr(8'h02, 32'd0);
    push_pkt(1'b0, 1, 4'd0, 1'b0, 4'd0);
    cycle();
    csr_wr(8'h02, 32'd0);
    run(3);
    chk_reg("clear_wins", 8'h02, 32'd0);
    chk("clear_pkts_out", 64'(outq.size()), 64'd3);
    outq.delete();

    // Reset during beat 2 of a 4-beat packet abandons it.
    rdy_rand = 1'b1;
    push_pkt(1'b0, 4, 4'd7, 1'b0, 4'd0);
    n = 0;
    while (outq.size() < 1 && n < 50) begin cycle(); n++; end
    chk("mid_first_beat", 64'(n < 50), 64'd1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_in_ready", 64'(st_in_ready), 64'd0);
    chk("mid_rst_gen_ready", 64'(gen_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(st_out_valid), 64'd0);
    inq.delete();
    st_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_readdata", 64'(csr_readdata), 64'd0);
    chk("mid_in_ready", 64'(st_in_ready), 64'd0);
    chk_reg("mid_status", 8'h05, 32'h4);
    chk_reg("mid_in_pkts", 8'h02, 32'd0);
    chk_reg("mid_gen_pkts", 8'h03, 32'd0);
    chk_reg("mid_drop", 8'h04, 32'd0);
    chk_reg("mid_inject", 8'h01, 32'd0);
    chk_reg("mid_unmapped", 8'h07, 32'hFFFF_FFFF);
    chk("mid_no_more_beats", 64'(outq.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fejkon_fc_inject.md
FEJKON_FC_INJECT -- requirements
Module: fejkon_fc_inject

Interface
REQ-001 Parameter DATA_WIDTH, default 256, stream data width in bits, multiple of 8.
REQ-002 Parameter CHANNEL_WIDTH, default 4, stream channel width.
REQ-003 Parameter EMPTY_WIDTH, default clog2(DATA_WIDTH/8), stream empty width.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 st_in_channel/data/empty/startofpacket/endofpacket/valid  in  CHANNEL_WIDTH/DATA_WIDTH/EMPTY_WIDTH/1/1/1  traffic stream, Avalon-ST, ready latency 0.
REQ-007 st_in_ready  out  1  traffic stream ready.
REQ-008 gen_channel/data/empty/startofpacket/endofpacket/valid  in  same widths  pattern-generator stream.
REQ-009 gen_ready  out  1  generator stream ready.
REQ-010 st_out_channel/data/empty/startofpacket/endofpacket/valid  out  same widths  merged stream.
REQ-011 st_out_ready  in  1  merged stream ready.
REQ-012 csr_address  in  8, csr_read  in  1, csr_write  in  1, csr_writedata  in  32, csr_readdata  out  32; Avalon-MM, read latency 1.

Function
REQ-013 Arbiter state machine SHALL have states IDLE, IN_PKT, GEN_PKT.
REQ-014 In IDLE: st_out_valid=0, all st_out fields 0, gen_ready=0.
REQ-015 In IDLE, input eligible when st_in_valid && st_in_startofpacket; generator eligible when gen_valid && gen_startofpacket && inject_enabled.
REQ-016 inject_enabled = (MODE==2) or (MODE==1 and INJECT_COUNT!=0).
REQ-017 Single eligible source granted next cycle (IDLE->IN_PKT or IDLE->GEN_PKT); both eligible: grant source not in last_src register; last_src resets to GEN, so input wins first.
REQ-018 In IDLE, st_in_ready=1 only while st_in_valid && !st_in_startofpacket; such beats discarded, DROP_COUNT +1 each.
REQ-019 In IN_PKT/GEN_PKT, st_out fields combinationally mux granted source, zero latency; granted ready = st_out_ready; other ready = 0.
REQ-020 In GEN_PKT with CTRL.override=1, st_out_channel SHALL equal CTRL.ovr_channel instead of gen_channel.
REQ-021 Granted state returns to IDLE on cycle after beat with valid && ready && endofpacket; last_src updated then; minimum one idle cycle between packets.
REQ-022 Mode or count changes mid-packet SHALL NOT truncate current packet; take effect at next IDLE decision.
REQ-023 INJECT_COUNT decrements by 1 on each accepted gen SOP beat in MODE 1; no decrement at 0 or in MODE 2.
REQ-024 CSR write to INJECT_COUNT same cycle as decrement: written value wins.
REQ-025 IN_PKTS and GEN_PKTS increment on accepted EOP beat of respective source; all counters 32-bit, saturate at 0xFFFFFFFF.
REQ-026 CSR map: 0x0 CTRL (bits[1:0] MODE: 0 off, 1 count, 2 continuous, 3 treated as 0; bit 2 override; bits[8+CHANNEL_WIDTH-1:8] ovr_channel); 0x1 INJECT_COUNT rw; 0x2 IN_PKTS; 0x3 GEN_PKTS; 0x4 DROP_COUNT; 0x5 STATUS (bits[1:0] state: 0 IDLE, 1 IN_PKT, 2 GEN_PKT; bit 2 last_src).
REQ-027 Any write to 0x2-0x4 clears that counter; increment same cycle as clear is lost.
REQ-028 csr_readdata registered, updated only on csr_read; unmapped addresses read 0xFFFFFFFF; unused CTRL bits read 0.

Reset
REQ-029 On reset: state IDLE, last_src=GEN, CTRL=0, INJECT_COUNT=0, all counters 0, csr_readdata=0.
REQ-030 While reset high, st_in_ready=0, gen_ready=0, st_out_valid=0.
REQ-031 Reset mid-packet SHALL abandon packet; no EOP emitted; no counter update.

Verification
REQ-032 MODE=0, 3-beat input packet, st_out_ready=1 -> output after 1-cycle grant, identical beats, IN_PKTS=1, gen_ready stays 0.
REQ-033 MODE=1, INJECT_COUNT=2, generator always valid 2-beat packets, no input -> exactly 2 gen packets out, INJECT_COUNT reads 0, GEN_PKTS=2.
REQ-034 MODE=2, both sources continuously valid -> packets alternate IN, GEN, IN, GEN; none interleaved mid-packet.
REQ-035 Input sends 2 non-SOP beats while IDLE -> both accepted, not forwarded, DROP_COUNT=2.
REQ-036 MODE=2, override=1, ovr_channel=5, gen_channel=2 -> st_out_channel=5 for all gen beats; MODE write to 0 mid gen packet -> packet completes, then no further gen grants.
REQ-037 Reset asserted during beat 2 of 4-beat packet with st_out_ready toggling -> next cycle state IDLE, readies 0, counters 0; read 0x7 -> 0xFFFFFFFF.
